piston_controller: RTL and testbench

//   Isobaric-mode counterpart of the pressure meter. The meter maps border, temp and moles to a

---
 rtl/piston_controller.sv | 158 +++++++++++++++
 tb/tb_piston_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/piston_controller.sv
// rtl/piston_controller.sv - converts a requested pressure into a target wall border and slews the border to it.
// Optional build macro PISTON_SNAP_EN: border jumps straight to the target instead of slewing.
module piston_controller #(
  parameter int          STEP_DIV     = 4,
  parameter logic [7:0]  RESET_BORDER = 8'd125
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       enable,
  input  logic       load,
  input  logic [6:0] target_q,
  input  logic [2:0] temp,
  input  logic [2:0] num_moles,
  output logic [7:0] border,
  output logic [2:0] vol_level,
  output logic       busy,
  output logic       done
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
`ifndef PISTON_SNAP_EN
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
`endif

  typedef enum logic [1:0] {IDLE, CALC, MOVE, HOLD} state_t;

  state_t        state, state_nx;
  logic [6:0]    rem, rem_nx;
  logic [4:0]    quo, quo_nx;
  logic [2:0]    temp_q, temp_nx;
  logic [2:0]    moles_q, moles_nx;
  logic [7:0]    tgt, tgt_nx;
  logic [7:0]    border_nx;
  logic [CW-1:0] step_cnt, cnt_nx;
  logic          done_nx;
  logic          busy_nx;

  // Quotient of the divide-by-5 loop minus the latched loads gives the volume level.
  logic signed [5:0] need;
  logic [2:0]        vol_calc;
  logic [7:0]        tgt_calc;

  assign need = $signed({1'b0, quo}) - $signed({3'b000, temp_q}) - $signed({3'b000, moles_q});

  always_comb begin
    vol_calc = 3'd1;
    if (need > 6'sd5)
      vol_calc = 3'd5;
    else if (need > 6'sd1)
      vol_calc = need[2:0];
  end

  always_comb begin
    tgt_calc = 8'd25;
    case (vol_calc)
      3'd2:    tgt_calc = 8'd75;
      3'd3:    tgt_calc = 8'd125;
      3'd4:    tgt_calc = 8'd175;
      3'd5:    tgt_calc = 8'd225;
      default: tgt_calc = 8'd25;
    endcase
  end

  always_comb begin
    state_nx  = state;
    rem_nx    = rem;
    quo_nx    = quo;
    temp_nx   = temp_q;
    moles_nx  = moles_q;
    tgt_nx    = tgt;
    border_nx = border;
    cnt_nx    = step_cnt;
    done_nx   = 1'b0;
    // A load always wins: it abandons any calculation or move in flight.
    if (load) begin
      rem_nx   = target_q;
      quo_nx   = 5'd0;
      temp_nx  = temp;
      moles_nx = num_moles;
      state_nx = CALC;
    end else begin
      case (state)
        CALC: begin
          if (rem >= 7'd5) begin
            rem_nx = rem - 7'd5;
            quo_nx = quo + 5'd1;
          end else begin
            tgt_nx = tgt_calc;
            if (border == tgt_calc) begin
              state_nx = HOLD;
              done_nx  = 1'b1;
            end else begin
              state_nx = MOVE;
              cnt_nx   = '0;
            end
          end
        end
        MOVE: begin
          if (enable) begin
`ifdef PISTON_SNAP_EN
            border_nx = tgt;
            state_nx  = HOLD;
            done_nx   = 1'b1;
`else
            if (step_cnt == LAST) begin
              cnt_nx    = '0;
              border_nx = (border < tgt) ? border + 8'd1 : border - 8'd1;
              if (border_nx == tgt) begin
                state_nx = HOLD;
                done_nx  = 1'b1;
              end
            end else begin
              cnt_nx = step_cnt + 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
    busy_nx = (state_nx == CALC) || (state_nx == MOVE);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state    <= IDLE;
      rem      <= '0;
      quo      <= '0;
      temp_q   <= '0;
      moles_q  <= '0;
      tgt      <= RESET_BORDER;
      border   <= RESET_BORDER;
      step_cnt <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      rem      <= rem_nx;
      quo      <= quo_nx;
      temp_q   <= temp_nx;
      moles_q  <= moles_nx;
      tgt      <= tgt_nx;
      border   <= border_nx;
      step_cnt <= cnt_nx;
      done     <= done_nx;
      busy     <= busy_nx;
    end
  end

  always_comb begin
    if (border < 8'd50)       vol_level = 3'd1;
    else if (border < 8'd100) vol_level = 3'd2;
    else if (border < 8'd150) vol_level = 3'd3;
    else if (border < 8'd200) vol_level = 3'd4;
    else                      vol_level = 3'd5;
  end

endmodule

// File: tb/tb_piston_controller.sv
// tb/tb_piston_controller.sv - directed scoreboard bench for piston_controller.
module tb_piston_controller;
  localparam int S = 4;
`ifdef PISTON_SNAP_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic       enable = 1'b1;
  logic       load = 1'b0;
  logic [6:0] target_q = '0;
  logic [2:0] temp = '0;
  logic [2:0] num_moles = '0;
  logic [7:0] border;
  logic [2:0] vol_level;
  logic       busy;
  logic       done;

  piston_controller #(.STEP_DIV(S), .RESET_BORDER(8'd125)) dut (
    .clk(clk), .clearn(clearn), .enable(enable), .load(load),
    .target_q(target_q), .temp(temp), .num_moles(num_moles),
    .border(border), .vol_level(vol_level), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int done_total = 0;
  int n_vec = 0;
  int n_bad = 0;
  int model_border = 125;

  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_total++;
  end

  typedef struct {
    int border;
    int vol;
    int lat;
    int load_cyc;
    int done_base;
  } exp_t;
  exp_t sb[$];

  function automatic int exp_tgt(input int tq, input int t, input int m);
    int need;
    int vol;
    need = tq / 5 - t - m;
    vol = (need < 1) ? 1 : (need > 5) ? 5 : need;
    return 25 + 50 * (vol - 1);
  endfunction

  function automatic int vol_of(input int b);
    if (b < 50) return 1;
    if (b < 100) return 2;
    if (b < 150) return 3;
    if (b < 200) return 4;
    return 5;
  endfunction

  function automatic int exp_lat(input int tq, input int from, input int to);
    int d;
    d = (from > to) ? from - to : to - from;
    if (d == 0) return tq / 5 + 1;
    return tq / 5 + 1 + (SNAP ? 1 : d * S);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic issue(input string tag, input int tq, input int t, input int m, input int extra);
    exp_t e;
    int tg;
    tg = exp_tgt(tq, t, m);
    target_q = tq[6:0];
    temp = t[2:0];
    num_moles = m[2:0];
    load = 1'b1;
    e.load_cyc = cyc + 1;
    e.done_base = done_total;
    e.border = tg;
    e.vol = vol_of(tg);
    e.lat = exp_lat(tq, model_border, tg) + extra;
    sb.push_back(e);
    model_border = tg;
    @(negedge clk);
    load = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 1);
  endtask

  task automatic abandon(input string tag);
    exp_t e;
    e = sb.pop_back();
    check({tag, "_nodone"}, done_total - e.done_base, 0);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int n;
    int b;
    e = sb.pop_front();
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, cyc - e.load_cyc, e.lat);
    check({tag, "_border"}, {24'd0, border}, e.border);
    check({tag, "_vol"}, {29'd0, vol_level}, e.vol);
    check({tag, "_busy_hold"}, {31'd0, busy}, 0);
    b = border;
    @(negedge clk);
    check({tag, "_one_done"}, done_total - e.done_base, 1);
    check({tag, "_done_fall"}, {31'd0, done}, 0);
    check({tag, "_border_stable"}, {24'd0, border}, e.border);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_border", {24'd0, border}, 125);
    check("rst_vol", {29'd0, vol_level}, 3);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    clearn = 1'b1;
    @(negedge clk);

    // Target equals current border: straight to HOLD.
    issue("same", 40, 3, 2, 0);
    wait_done("same");

    issue("up225", 50, 2, 3, 0);
    wait_done("up225");

    issue("clamp_lo", 10, 3, 4, 0);
    wait_done("clamp_lo");

    issue("clamp_hi", 127, 0, 0, 0);
    wait_done("clamp_hi");

    // Retarget mid-move from 225 toward 25: new target 75.
    issue("abandon", 10, 3, 4, 0);
    repeat (SNAP ? 2 : 3 + 20 * S) @(negedge clk);
    check("mid_border", {24'd0, border}, SNAP ? 225 : 205);
    abandon("abandon");
    model_border = SNAP ? 225 : 205;
    issue("reverse", 35, 3, 2, 0);
    check("reload_keep", {24'd0, border}, SNAP ? 225 : 205);
    wait_done("reverse");

    // Load collides with the arrival edge: no done, border held one short.
    issue("collide_a", 40, 3, 2, 0);
    repeat (exp_lat(40, 75, 125) - 1) @(negedge clk);
    abandon("collide_a");
    model_border = SNAP ? 75 : 124;
    issue("collide_b", 40, 3, 2, 0);
    wait_done("collide_b");

    // Pause mid-move for 20 cycles.
    issue("pause", 50, 2, 3, 20);
    repeat (SNAP ? 10 : 10 + 10 * S + 2) @(negedge clk);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("pause_frozen", {24'd0, border}, SNAP ? 125 : 135);
    enable = 1'b1;
    wait_done("pause");

    // Asynchronous reset mid-move.
    issue("areset", 10, 3, 4, 0);
    repeat (SNAP ? 2 : 3 + 5 * S) @(negedge clk);
    #2 clearn = 1'b0;
    #1;
    check("areset_border", {24'd0, border}, 125);
    check("areset_busy", {31'd0, busy}, 0);
    check("areset_done", {31'd0, done}, 0);
    void'(sb.pop_back());
    @(negedge clk);
    clearn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 0);
    check("post_rst_border", {24'd0, border}, 125);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
